// File: rtl/hidden_backprop.sv
// hidden_backprop: backward pass for the 3-neuron, 2-input hidden layer.
// Derives the hidden deltas and the wa/wb/bias gradients from the output-layer delta.
// A single time-shared signed fixed-point multiplier runs under a start/done FSM.
// Per neuron k the multiplier performs six steps: p, q, d, g, g*A and g*B.
// Optional feature macro BACKPROP_SAT_EN makes every multiply saturate.
// Without the macro, the shifted product wraps to DWIDTH bits.
//
// state | meaning
// IDLE  | waiting for start; operands are latched on start
// CALC  | 18 multiply steps (k = 0..2, step = 0..5)
// DONE  | results published; done pulses in the following cycle
module hidden_backprop #(
  parameter int DWIDTH = 32,
  parameter int frac   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  input  logic [DWIDTH-1:0] h1,
  input  logic [DWIDTH-1:0] h2,
  input  logic [DWIDTH-1:0] h3,
  input  logic [DWIDTH-1:0] wo1,
  input  logic [DWIDTH-1:0] wo2,
  input  logic [DWIDTH-1:0] wo3,
  input  logic [DWIDTH-1:0] delta_o,
  input  logic [DWIDTH-1:0] lr,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] dwa1,
  output logic [DWIDTH-1:0] dwa2,
  output logic [DWIDTH-1:0] dwa3,
  output logic [DWIDTH-1:0] dwb1,
  output logic [DWIDTH-1:0] dwb2,
  output logic [DWIDTH-1:0] dwb3,
  output logic [DWIDTH-1:0] dbias1,
  output logic [DWIDTH-1:0] dbias2,
  output logic [DWIDTH-1:0] dbias3
);

  localparam logic signed [DWIDTH-1:0] ONE = {{(DWIDTH-1){1'b0}}, 1'b1} << frac;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [2:0]  step_q, step_d;
  logic        done_q;
  logic        last_step;

  logic signed [DWIDTH-1:0] a_q, b_q, delta_q, lr_q;
  logic signed [DWIDTH-1:0] h_q [3];
  logic signed [DWIDTH-1:0] wo_q [3];
  logic signed [DWIDTH-1:0] p_q, q_q, d_q, g_q;
  logic signed [DWIDTH-1:0] ga_q [3];
  logic signed [DWIDTH-1:0] gb_q [3];
  logic signed [DWIDTH-1:0] gbias_q [3];
  logic [DWIDTH-1:0] out_a_q [3];
  logic [DWIDTH-1:0] out_b_q [3];
  logic [DWIDTH-1:0] out_bias_q [3];

  logic signed [DWIDTH-1:0]   h_sel, wo_sel, op_a, op_b, mul_res;
  logic signed [2*DWIDTH-1:0] prod_full;
  logic                       unused_bits;

  // Operand selection for the shared multiplier, driven by the current neuron/step.
  always_comb begin
    h_sel  = '0;
    wo_sel = '0;
    op_a   = '0;
    op_b   = '0;
    case (k_q)
      2'd0:    begin h_sel = h_q[0]; wo_sel = wo_q[0]; end
      2'd1:    begin h_sel = h_q[1]; wo_sel = wo_q[1]; end
      2'd2:    begin h_sel = h_q[2]; wo_sel = wo_q[2]; end
      default: begin h_sel = '0;     wo_sel = '0;     end
    endcase
    case (step_q)
      3'd0:    begin op_a = h_sel;   op_b = ONE - h_sel; end
      3'd1:    begin op_a = delta_q; op_b = wo_sel;      end
      3'd2:    begin op_a = p_q;     op_b = q_q;         end
      3'd3:    begin op_a = lr_q;    op_b = d_q;         end
      3'd4:    begin op_a = g_q;     op_b = a_q;         end
      3'd5:    begin op_a = g_q;     op_b = b_q;         end
      default: begin op_a = '0;      op_b = '0;          end
    endcase
  end

  assign prod_full = (2*DWIDTH)'(op_a) * (2*DWIDTH)'(op_b);

`ifdef BACKPROP_SAT_EN
  logic fits;
  // Shifted product fits when every bit above the result's sign bit equals that sign bit.
  always_comb begin
    fits = (&prod_full[2*DWIDTH-1:frac+DWIDTH-1]) | ~(|prod_full[2*DWIDTH-1:frac+DWIDTH-1]);
    if (fits)
      mul_res = prod_full[frac +: DWIDTH];
    else if (prod_full[2*DWIDTH-1])
      mul_res = {1'b1, {(DWIDTH-1){1'b0}}};
    else
      mul_res = {1'b0, {(DWIDTH-1){1'b1}}};
  end
  assign unused_bits = ^prod_full[frac-1:0];
`else
  // Arithmetic shift right by frac then keep the low DWIDTH bits (wraps on overflow).
  assign mul_res     = prod_full[frac +: DWIDTH];
  assign unused_bits = ^{prod_full[frac-1:0], prod_full[2*DWIDTH-1:frac+DWIDTH]};
`endif

  assign last_step = (state_q == CALC) && (k_q == 2'd2) && (step_q == 3'd5);

  // Next-state logic for the FSM and the neuron/step sequencer.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          k_d     = 2'd0;
          step_d  = 3'd0;
        end
      end
      CALC: begin
        if (last_step) begin
          state_d = DONE;
        end else if (step_q == 3'd5) begin
          step_d = 3'd0;
          k_d    = k_q + 2'd1;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, sequencer and the registered done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      step_q  <= step_d;
      done_q  <= (state_q == DONE);
    end
  end

  // Operand latch, per-step multiply results, shadow gradients and published outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      delta_q <= '0;
      lr_q    <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      g_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        h_q[i]        <= '0;
        wo_q[i]       <= '0;
        ga_q[i]       <= '0;
        gb_q[i]       <= '0;
        gbias_q[i]    <= '0;
        out_a_q[i]    <= '0;
        out_b_q[i]    <= '0;
        out_bias_q[i] <= '0;
      end
    end else if (state_q == IDLE) begin
      if (start) begin
        a_q     <= A;
        b_q     <= B;
        delta_q <= delta_o;
        lr_q    <= lr;
        h_q[0]  <= h1;
        h_q[1]  <= h2;
        h_q[2]  <= h3;
        wo_q[0] <= wo1;
        wo_q[1] <= wo2;
        wo_q[2] <= wo3;
      end
    end else if (state_q == CALC) begin
      case (step_q)
        3'd0: p_q <= mul_res;
        3'd1: q_q <= mul_res;
        3'd2: d_q <= mul_res;
        3'd3: begin
          g_q          <= mul_res;
          gbias_q[k_q] <= mul_res;
        end
        3'd4: ga_q[k_q] <= mul_res;
        3'd5: gb_q[k_q] <= mul_res;
        default: ;
      endcase
      // The final g*B lands on the same edge as the publish, so it bypasses its shadow.
      if (last_step) begin
        for (int i = 0; i < 3; i++) begin
          out_a_q[i]    <= ga_q[i];
          out_bias_q[i] <= gbias_q[i];
        end
        out_b_q[0] <= gb_q[0];
        out_b_q[1] <= gb_q[1];
        out_b_q[2] <= mul_res;
      end
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = done_q;
  assign dwa1   = out_a_q[0];
  assign dwa2   = out_a_q[1];
  assign dwa3   = out_a_q[2];
  assign dwb1   = out_b_q[0];
  assign dwb2   = out_b_q[1];
  assign dwb3   = out_b_q[2];
  assign dbias1 = out_bias_q[0];
  assign dbias2 = out_bias_q[1];
  assign dbias3 = out_bias_q[2];

endmodule

// File: tb/tb_hidden_backprop.sv
// Directed bench for hidden_backprop with a scoreboard queue of expected gradient sets.
// Expected sets are pushed when a run is launched and popped when done is observed.
// Honours BACKPROP_SAT_EN for the overflow case.
module tb_hidden_backprop;

  typedef struct packed {
    logic [31:0] a, b, h1, h2, h3, w1, w2, w3, dlt, lr;
  } vec_t;
  typedef logic [8:0][31:0] res_t;  // [0..2] dwa, [3..5] dwb, [6..8] dbias

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A, B, h1, h2, h3, wo1, wo2, wo3, delta_o, lr;
  logic        busy, done;
  logic [31:0] dwa1, dwa2, dwa3, dwb1, dwb2, dwb3, dbias1, dbias2, dbias3;

  int   tests = 0;
  int   fails = 0;
  res_t exp_q [$];

  hidden_backprop dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B), .h1(h1), .h2(h2), .h3(h3),
    .wo1(wo1), .wo2(wo2), .wo3(wo3), .delta_o(delta_o), .lr(lr),
    .busy(busy), .done(done),
    .dwa1(dwa1), .dwa2(dwa2), .dwa3(dwa3),
    .dwb1(dwb1), .dwb2(dwb2), .dwb3(dwb3),
    .dbias1(dbias1), .dbias2(dbias2), .dbias3(dbias3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic res_t get_out();
    res_t r;
    r[0] = dwa1;  r[1] = dwa2;  r[2] = dwa3;
    r[3] = dwb1;  r[4] = dwb2;  r[5] = dwb3;
    r[6] = dbias1; r[7] = dbias2; r[8] = dbias3;
    return r;
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    p = p >>> 24;
`ifdef BACKPROP_SAT_EN
    if (p > 64'sh0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
    if (p < -64'sh0000_0000_8000_0000) return 32'h8000_0000;
`endif
    return p[31:0];
  endfunction

  function automatic res_t model(input vec_t v);
    res_t r;
    logic [31:0] hk, wk, p, q, d, g;
    for (int k = 0; k < 3; k++) begin
      hk = (k == 0) ? v.h1 : (k == 1) ? v.h2 : v.h3;
      wk = (k == 0) ? v.w1 : (k == 1) ? v.w2 : v.w3;
      p = fmul(hk, 32'h0100_0000 - hk);
      q = fmul(v.dlt, wk);
      d = fmul(p, q);
      g = fmul(v.lr, d);
      r[k]   = fmul(g, v.a);
      r[3+k] = fmul(g, v.b);
      r[6+k] = g;
    end
    return r;
  endfunction

  task automatic apply(input vec_t v);
    A = v.a; B = v.b; h1 = v.h1; h2 = v.h2; h3 = v.h3;
    wo1 = v.w1; wo2 = v.w2; wo3 = v.w3; delta_o = v.dlt; lr = v.lr;
  endtask

  // Drive a vector with start=1 into edge N; start is left high when hold is set.
  task automatic launch(input vec_t v, input bit hold);
    @(negedge clk);
    apply(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Follows one run from the cycle after edge N; j counts negedges from that cycle.
  task automatic run_check(input string tag, input res_t prev, input bit pulse);
    int   lat = -1;
    res_t e, o;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (j == 0)  check({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
      if (j == 17) check({tag, "_busy_last"}, {31'd0, busy}, 32'd1);
      if (j == 18) check({tag, "_busy_done_state"}, {31'd0, busy}, 32'd0);
      if (j == 9) begin
        check({tag, "_hold_dwb1"}, dwb1, prev[3]);
        check({tag, "_hold_dbias3"}, dbias3, prev[8]);
      end
      if (pulse) begin
        if (j == 1) apply('{default: 32'hDEAD_BEEF});
        start = (j == 4 || j == 18) ? 1'b1 : 1'b0;
      end
      if (done) begin
        lat = j;
        break;
      end
    end
    if (pulse) start = 1'b0;
    check({tag, "_latency"}, lat, 32'd19);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      o = get_out();
      for (int i = 0; i < 9; i++) check($sformatf("%s_out%0d", tag, i), o[i], e[i]);
    end
  endtask

  function automatic res_t rep(input logic [31:0] ga, input logic [31:0] gb, input logic [31:0] gg);
    res_t r;
    for (int k = 0; k < 3; k++) begin
      r[k] = ga; r[3+k] = gb; r[6+k] = gg;
    end
    return r;
  endfunction

  initial begin
    vec_t v2, v3, v4, vr;
    res_t r2, r3, r4, r0, rr;
    int   ndone;

    v2 = '{a: 32'h0100_0000, b: 32'hFE00_0000, h1: 32'h0080_0000, h2: 32'h0080_0000,
           h3: 32'h0080_0000, w1: 32'h0100_0000, w2: 32'h0100_0000, w3: 32'h0100_0000,
           dlt: 32'h0100_0000, lr: 32'h0080_0000};
    r2 = rep(32'h0020_0000, 32'hFFC0_0000, 32'h0020_0000);
    v3 = v2;
    v3.h1 = 32'h0000_0000;
    v3.h2 = 32'h0100_0000;
    r3 = rep(32'h0, 32'h0, 32'h0);
    r3[2] = 32'h0020_0000; r3[5] = 32'hFFC0_0000; r3[8] = 32'h0020_0000;
    v4 = '{a: 32'h0100_0000, b: 32'h0, h1: 32'h0080_0000, h2: 32'h0, h3: 32'h0,
           w1: 32'h6400_0000, w2: 32'h0, w3: 32'h0, dlt: 32'h6400_0000, lr: 32'h0100_0000};
    r4 = rep(32'h0, 32'h0, 32'h0);
`ifdef BACKPROP_SAT_EN
    r4[0] = 32'h1FFF_FFFF; r4[6] = 32'h1FFF_FFFF;
`else
    r4[0] = 32'h0400_0000; r4[6] = 32'h0400_0000;
`endif
    r0 = '0;
    apply(v2);

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dwa1", dwa1, 32'd0);
    check("rst_dbias3", dbias3, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Nominal run
    exp_q.push_back(r2);
    launch(v2, 1'b0);
    run_check("t2", r0, 1'b0);

    // Saturated/zero sigmoid derivatives
    exp_q.push_back(r3);
    launch(v3, 1'b0);
    run_check("t3", r2, 1'b0);

    // Asynchronous reset mid-run
    launch(v2, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_dwa3", dwa3, 32'd0);
    check("abort_dwb3", dwb3, 32'd0);
    check("abort_dbias3", dbias3, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 32'd0);

    // Overflow in q
    exp_q.push_back(r4);
    launch(v4, 1'b0);
    run_check("t4", r0, 1'b0);

    // start pulses during CALC and DONE are ignored; inputs scrambled after edge N
    exp_q.push_back(r2);
    launch(v2, 1'b0);
    run_check("t5", r4, 1'b1);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("t5_single_run", ndone, 32'd0);

    // start held high: back-to-back runs
    exp_q.push_back(r3);
    exp_q.push_back(r3);
    launch(v3, 1'b1);
    run_check("t6a", r2, 1'b0);
    run_check("t6b", r3, 1'b0);
    start = 1'b0;

    // Model-checked random vector
    vr.a  = $urandom_range(0, 32'h0400_0000) - 32'h0200_0000;
    vr.b  = $urandom_range(0, 32'h0400_0000) - 32'h0200_0000;
    vr.h1 = $urandom_range(0, 32'h0100_0000);
    vr.h2 = $urandom_range(0, 32'h0100_0000);
    vr.h3 = $urandom_range(0, 32'h0100_0000);
    vr.w1 = $urandom_range(0, 32'h0400_0000) - 32'h0200_0000;
    vr.w2 = $urandom_range(0, 32'h0400_0000) - 32'h0200_0000;
    vr.w3 = $urandom_range(0, 32'h0400_0000) - 32'h0200_0000;
    vr.dlt = $urandom_range(0, 32'h0400_0000) - 32'h0200_0000;
    vr.lr = $urandom_range(0, 32'h0100_0000);
    rr = model(vr);
    exp_q.push_back(rr);
    launch(vr, 1'b0);
    run_check("rand", r3, 1'b0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
